// File: rtl/dual_edge_ff_pkg.sv
// Shared types and constants for the dual_edge_ff burst arbiter.
package dual_edge_ff_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Edge-select codes carried with every beat.
    localparam logic [1:0] EDGE_NONE = 2'b00;
    localparam logic [1:0] EDGE_POS  = 2'b01;
    localparam logic [1:0] EDGE_NEG  = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dual_edge_ff_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping around to index 0.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan N slots starting at ptr; the first valid slot wins.
    always_comb begin
        logic [IW:0] slot;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        slot = '0;
        for (int k = 0; k < N; k++) begin
            slot = {1'b0, ptr} + (IW+1)'(k);
            if (slot >= (IW+1)'(N)) begin
                slot = slot - (IW+1)'(N);
            end
            if (!any && req[slot[IW-1:0]]) begin
                any                = 1'b1;
                gnt[slot[IW-1:0]]  = 1'b1;
                idx                = slot[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/dual_edge_ff_arb.sv
// Round-robin burst arbiter sharing one dual_edge_ff between NUM_REQ
// requesters. Beats carry {data, mask, edge}; the granted beat is registered
// and presented to the FF one cycle after it transfers.
//
// Handshake: a beat transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high. req_ready is combinational from state and
// req_valid, never depends on the beat payload, and is held low in reset.
module dual_edge_ff_arb
    import dual_edge_ff_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 4,
    parameter int IDLE_TIMEOUT = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_mask,
    input  logic [NUM_REQ*2-1:0]            req_edge,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [DATA_WIDTH-1:0]           ff_data_in,
    output logic [DATA_WIDTH-1:0]           ff_pos_en,
    output logic [DATA_WIDTH-1:0]           ff_neg_en,
    output logic                            grant_valid,
    output logic [clog2_min1(NUM_REQ)-1:0]  grant_id,
    output logic                            busy,
    output state_t                          fsm_state
);

    localparam int         IW     = clog2_min1(NUM_REQ);
    localparam logic [4:0] MAX_B  = 5'(MAX_BURST);
    localparam logic [7:0] TO_CNT = 8'(IDLE_TIMEOUT);

    state_t                  state, state_nxt;
    logic [IW-1:0]           rr_ptr;
    logic [4:0]              beat_cnt;
    logic [7:0]              bubble_cnt;

    logic [NUM_REQ-1:0]      pick_gnt;
    logic [IW-1:0]           pick_idx;
    logic                    pick_any;
    logic [NUM_REQ-1:0]      owner_oh;
    logic [IW-1:0]           sel_idx;
    logic [DATA_WIDTH-1:0]   sel_data, sel_mask;
    logic [1:0]              sel_edge;
    logic                    sel_last;
    logic                    xfer, at_limit, end_burst, timeout, rel;
    logic [4:0]              beat_inc;
    logic [7:0]              bubble_inc;
    logic [IW-1:0]           ptr_after;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign owner_oh = NUM_REQ'(1) << grant_id;
    assign sel_idx  = (state == IDLE) ? pick_idx : grant_id;

    // Mux the payload of whichever requester is currently selected.
    always_comb begin
        sel_data = '0;
        sel_mask = '0;
        sel_edge = EDGE_NONE;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == IW'(i)) begin
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_mask = req_mask[i*DATA_WIDTH +: DATA_WIDTH];
                sel_edge = req_edge[i*2 +: 2];
                sel_last = req_last[i];
            end
        end
    end

    assign xfer       = |(req_valid & req_ready);
    assign beat_inc   = beat_cnt + 5'd1;
    assign bubble_inc = bubble_cnt + 8'd1;
    assign at_limit   = (state == IDLE) ? (MAX_BURST == 1) : (beat_inc == MAX_B);
    assign end_burst  = xfer & (sel_last | at_limit);
    assign timeout    = (state == BURST) & ~xfer & (bubble_inc == TO_CNT);
    assign rel        = end_burst | timeout;
    assign ptr_after  = (sel_idx == IW'(NUM_REQ-1)) ? '0 : sel_idx + IW'(1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: a non-final beat in IDLE opens a burst; release on
    // last, MAX_BURST or owner bubble timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer && !end_burst) state_nxt = BURST;
            BURST:   if (rel)                state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready: arbitration winner in IDLE, owner only in BURST, none in reset.
    always_comb begin
        req_ready = '0;
        if (!rst) begin
            case (state)
                IDLE:    req_ready = pick_any ? pick_gnt : '0;
                BURST:   req_ready = owner_oh;
                default: req_ready = '0;
            endcase
        end
    end

    // Pointer, owner and burst/bubble counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            beat_cnt   <= '0;
            bubble_cnt <= '0;
            grant_id   <= '0;
        end else begin
            if (xfer) begin
                beat_cnt   <= (state == IDLE) ? 5'd1 : beat_inc;
                bubble_cnt <= '0;
            end else if (state == BURST) begin
                bubble_cnt <= timeout ? 8'd0 : bubble_inc;
            end
            if (state == IDLE && xfer) grant_id <= pick_idx;
            if (rel)                   rr_ptr   <= ptr_after;
        end
    end

    // Output register: enables pulse for one cycle per beat, data holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_data_in <= '0;
            ff_pos_en  <= '0;
            ff_neg_en  <= '0;
        end else if (xfer) begin
            ff_data_in <= sel_data;
            ff_pos_en  <= sel_mask & {DATA_WIDTH{sel_edge[0]}};
            ff_neg_en  <= sel_mask & {DATA_WIDTH{sel_edge[1]}};
        end else begin
            ff_pos_en  <= '0;
            ff_neg_en  <= '0;
        end
    end

    assign grant_valid = (state == BURST);
    assign busy        = grant_valid | (|ff_pos_en) | (|ff_neg_en);
    assign fsm_state   = state;

endmodule

// File: tb/tb_dual_edge_ff_arb.sv
// Directed bench for dual_edge_ff_arb: per-requester beat tables drive the
// ports, expected FF beats are queued by hand, a negedge monitor compares.
module tb_dual_edge_ff_arb;
    import dual_edge_ff_pkg::*;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int EW = 3*W + 2 + 1;

    logic            clk, rst;
    logic [N-1:0]    req_valid, req_ready, req_last;
    logic [N*W-1:0]  req_data, req_mask;
    logic [N*2-1:0]  req_edge;
    logic [W-1:0]    ff_data_in, ff_pos_en, ff_neg_en;
    logic            grant_valid, busy;
    logic [1:0]      grant_id;
    state_t          fsm_state;

    dual_edge_ff_arb #(.DATA_WIDTH(W), .NUM_REQ(N), .MAX_BURST(4), .IDLE_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_mask(req_mask), .req_edge(req_edge), .req_last(req_last),
        .ff_data_in(ff_data_in), .ff_pos_en(ff_pos_en), .ff_neg_en(ff_neg_en),
        .grant_valid(grant_valid), .grant_id(grant_id), .busy(busy), .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    logic [EW-1:0] exp_q[$];
    logic          mon_en    = 1'b0;
    logic          prev_xfer = 1'b0;
    logic [W-1:0]  last_data = '0;

    logic [W-1:0]  s_data[N][16];
    logic [W-1:0]  s_mask[N][16];
    logic [1:0]    s_edge[N][16];
    logic          s_last[N][16];
    int            s_delay[N][16];
    int            s_cnt[N], s_head[N], s_wait[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < N; i++) begin
            s_cnt[i]  = 0;
            s_head[i] = 0;
            s_wait[i] = 0;
        end
    endtask

    task automatic add_beat(input int r, input logic [W-1:0] d, input logic [W-1:0] m,
                            input logic [1:0] e, input logic l, input int dly);
        s_data[r][s_cnt[r]]  = d;
        s_mask[r][s_cnt[r]]  = m;
        s_edge[r][s_cnt[r]]  = e;
        s_last[r][s_cnt[r]]  = l;
        s_delay[r][s_cnt[r]] = dly;
        s_cnt[r]++;
    endtask

    task automatic expect_beat(input logic [W-1:0] d, input logic [W-1:0] p,
                               input logic [W-1:0] ng, input int id, input logic gv);
        exp_q.push_back({d, p, ng, 2'(id), gv});
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (s_head[i] < s_cnt[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_reset();
        mon_en    = 1'b0;
        req_valid = '0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        exp_q.delete();
        prev_xfer = 1'b0;
        last_data = '0;
        clear_stim();
        mon_en    = 1'b1;
    endtask

    // Present table heads each cycle; advance a table when its beat fires.
    task automatic run(input int budget, output int used);
        logic [N-1:0] fire;
        for (int i = 0; i < N; i++) s_wait[i] = (s_cnt[i] > 0) ? s_delay[i][0] : 0;
        used = 0;
        while (pending() && used < budget) begin
            for (int i = 0; i < N; i++) begin
                if (s_head[i] < s_cnt[i] && s_wait[i] == 0) begin
                    req_valid[i]        = 1'b1;
                    req_data[i*W +: W]  = s_data[i][s_head[i]];
                    req_mask[i*W +: W]  = s_mask[i][s_head[i]];
                    req_edge[i*2 +: 2]  = s_edge[i][s_head[i]];
                    req_last[i]         = s_last[i][s_head[i]];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            @(negedge clk);
            fire = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (fire[i]) begin
                    s_head[i]++;
                    if (s_head[i] < s_cnt[i]) s_wait[i] = s_delay[i][s_head[i]];
                end else if (s_wait[i] > 0) begin
                    s_wait[i]--;
                end
            end
            used++;
        end
        req_valid = '0;
        if (pending()) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: beats still pending after %0d cycles", budget);
        end
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge clk);
        #1;
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e, got;
        logic          exp_busy;
        if (mon_en) begin
            if (prev_xfer) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: data %h pos %h neg %h", ff_data_in, ff_pos_en, ff_neg_en);
                end else begin
                    e   = exp_q.pop_front();
                    got = {ff_data_in, ff_pos_en, ff_neg_en, grant_id, grant_valid};
                    chk("beat{data,pos,neg,id,gv}", 32'(got), 32'(e));
                    exp_busy = e[0] | (|e[2*W+2:W+3]) | (|e[W+2:3]);
                    chk("busy", 32'(busy), 32'(exp_busy));
                    last_data = e[EW-1 -: W];
                end
            end else begin
                chk("idle_enables", {16'd0, ff_pos_en, ff_neg_en}, 32'd0);
                chk("hold_data", 32'(ff_data_in), 32'(last_data));
            end
            prev_xfer = |(req_valid & req_ready);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int used;
        req_valid = '0; req_data = '0; req_mask = '0; req_edge = '0; req_last = '0;
        clear_stim();

        // Reset state, ready gated while rst is high.
        rst = 1'b1;
        req_valid = 4'b0001;
        #12;
        chk("rst_data", 32'(ff_data_in), 32'd0);
        chk("rst_en", {16'd0, ff_pos_en, ff_neg_en}, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_grant", {30'd0, grant_valid, busy}, 32'd0);
        chk("rst_id", 32'(grant_id), 32'd0);
        do_reset();

        // Single beat from req1, then pointer sits at 2.
        add_beat(1, 8'hA5, 8'hFF, EDGE_POS, 1'b1, 0);
        expect_beat(8'hA5, 8'hFF, 8'h00, 1, 1'b0);
        run(10, used);
        chk("single_cycles", 32'(used), 32'd1);
        clear_stim();
        add_beat(0, 8'h01, 8'hFF, EDGE_POS,  1'b1, 0);
        add_beat(1, 8'h02, 8'hAA, EDGE_BOTH, 1'b1, 0);
        add_beat(2, 8'h03, 8'h55, EDGE_NEG,  1'b1, 0);
        expect_beat(8'h03, 8'h00, 8'h55, 2, 1'b0);
        expect_beat(8'h01, 8'hFF, 8'h00, 0, 1'b0);
        expect_beat(8'h02, 8'hAA, 8'hAA, 1, 1'b0);
        run(10, used);
        chk("ptr2_cycles", 32'(used), 32'd3);
        drain("single_drain");

        // Fairness: all hold valid with single-beat bursts.
        do_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < N; r++)
                add_beat(r, 8'(8'h40 + 8*b + r), 8'hFF, EDGE_POS, 1'b1, 0);
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < N; r++)
                expect_beat(8'(8'h40 + 8*b + r), 8'hFF, 8'h00, r, 1'b0);
        run(20, used);
        chk("fair_cycles", 32'(used), 32'd8);
        drain("fair_drain");

        // MAX_BURST: 6 non-last beats split 4 + 2.
        do_reset();
        for (int b = 0; b < 6; b++) add_beat(2, 8'(8'h20 + b), 8'hFF, EDGE_POS, 1'b0, 0);
        for (int b = 0; b < 6; b++) expect_beat(8'(8'h20 + b), 8'hFF, 8'h00, 2, (b != 3));
        run(20, used);
        chk("maxb_cycles", 32'(used), 32'd6);
        drain("maxb_drain");

        // Bubble timeout: req0 stalls 8 cycles, req3 takes over.
        do_reset();
        add_beat(0, 8'h11, 8'hFF, EDGE_POS,  1'b0, 0);
        add_beat(0, 8'h22, 8'h3C, EDGE_NEG,  1'b1, 8);
        add_beat(3, 8'h33, 8'h0F, EDGE_BOTH, 1'b1, 0);
        expect_beat(8'h11, 8'hFF, 8'h00, 0, 1'b1);
        expect_beat(8'h33, 8'h0F, 8'h0F, 3, 1'b0);
        expect_beat(8'h22, 8'h00, 8'h3C, 0, 1'b0);
        run(30, used);
        chk("bubble_cycles", 32'(used), 32'd11);
        drain("bubble_drain");

        // Edge codes; the null beat counts toward the 4-beat limit.
        do_reset();
        add_beat(1, 8'h3C, 8'h0F, EDGE_NEG,  1'b0, 0);
        add_beat(1, 8'h5A, 8'hF0, EDGE_BOTH, 1'b0, 0);
        add_beat(1, 8'h77, 8'hFF, EDGE_NONE, 1'b0, 0);
        add_beat(1, 8'h99, 8'h81, EDGE_POS,  1'b0, 0);
        expect_beat(8'h3C, 8'h00, 8'h0F, 1, 1'b1);
        expect_beat(8'h5A, 8'hF0, 8'hF0, 1, 1'b1);
        expect_beat(8'h77, 8'h00, 8'h00, 1, 1'b1);
        expect_beat(8'h99, 8'h81, 8'h00, 1, 1'b0);
        run(10, used);
        chk("edge_cycles", 32'(used), 32'd4);
        drain("edge_drain");

        // Asynchronous reset mid-burst, then req0 wins first.
        do_reset();
        expect_beat(8'hC3, 8'hFF, 8'hFF, 1, 1'b1);
        req_valid = 4'b0010;
        req_data[1*W +: W] = 8'hC3; req_mask[1*W +: W] = 8'hFF;
        req_edge[1*2 +: 2] = EDGE_BOTH; req_last[1] = 1'b0;
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        #1;
        req_valid = 4'b1111;
        #1;
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        chk("midrst_data", 32'(ff_data_in), 32'd0);
        chk("midrst_en", {16'd0, ff_pos_en, ff_neg_en}, 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        chk("midrst_grant", {30'd0, grant_valid, busy}, 32'd0);
        chk("midrst_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = '0;
        prev_xfer = 1'b0;
        last_data = '0;
        clear_stim();
        for (int r = 0; r < N; r++) add_beat(r, 8'(8'h60 + r), 8'hFF, EDGE_NEG, 1'b1, 0);
        for (int r = 0; r < N; r++) expect_beat(8'(8'h60 + r), 8'h00, 8'hFF, r, 1'b0);
        mon_en = 1'b1;
        run(20, used);
        chk("postrst_cycles", 32'(used), 32'd4);
        drain("postrst_drain");

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dual_edge_ff_arb.md
Name: dual_edge_ff_arb

Overview:
Round-robin burst arbiter that shares one dual_edge_ff instance between NUM_REQ requesters. Each requester pushes beats of {data, bit mask, edge select} over valid/ready. The arbiter grants one requester per burst and drives the FF's data_in, pos_edge_latch_en and neg_edge_latch_en from registered outputs. It sits directly in front of dual_edge_ff; the FF itself is instantiated outside this block.

Parameters:
DATA_WIDTH, 8, width of data and mask per beat; matches dual_edge_ff DATA_WIDTH
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 4, maximum beats per grant before forced release (1..16)
IDLE_TIMEOUT, 8, consecutive owner-bubble cycles in BURST before forced release (1..255)

Ports:
clk  in  1  clock; single clock domain, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester beat valid
req_ready  out  NUM_REQ  per-requester beat accept (combinational)
req_data  in  NUM_REQ*DATA_WIDTH  beat data; requester i occupies slice i
req_mask  in  NUM_REQ*DATA_WIDTH  per-bit latch mask
req_edge  in  NUM_REQ*2  edge select; bit0 = pos edge, bit1 = neg edge
req_last  in  NUM_REQ  final beat of the burst
ff_data_in  out  DATA_WIDTH  to dual_edge_ff data_in
ff_pos_en  out  DATA_WIDTH  to dual_edge_ff pos_edge_latch_en
ff_neg_en  out  DATA_WIDTH  to dual_edge_ff neg_edge_latch_en
grant_valid  out  1  a burst is owned (state BURST)
grant_id  out  $clog2(NUM_REQ)  current or last owner
busy  out  1  grant_valid, or any enable bit nonzero

Behaviour:
- Reset (asynchronous, any time): state IDLE; rr_ptr = 0; beat_cnt = 0; bubble_cnt = 0. All outputs are 0. req_ready is 0 while rst is high.
- Reset mid-burst: the burst is abandoned and the beat in the output register is lost. The requester must resend any beat it had not seen accepted.
- Transfer: a beat transfers when req_valid[i] and req_ready[i] are both high.
- Output latency is 1 cycle. On the cycle after a transfer:
  - ff_data_in = data
  - ff_pos_en = mask & {DATA_WIDTH{edge[0]}}
  - ff_neg_en = mask & {DATA_WIDTH{edge[1]}}
- On any cycle with no transfer, ff_pos_en and ff_neg_en are 0 and ff_data_in holds its last value, so the FF retains its state.
- edge = 00 is a null beat: it is accepted, counts toward beat_cnt, and produces no enables.
- State IDLE:
  - The winner is the first valid requester searching from rr_ptr upward with wrap-around. req_ready is high for the winner only.
  - On a transfer, beat_cnt becomes 1 and grant_id becomes the winner.
  - If the beat has last = 1 or MAX_BURST == 1: stay in IDLE and set rr_ptr = winner + 1 (mod NUM_REQ).
  - Otherwise go to BURST.
- State BURST:
  - req_ready is high only for the owner (grant_id). All other requesters see ready = 0.
  - On a transfer: beat_cnt increments and bubble_cnt clears. If last = 1 or beat_cnt + 1 == MAX_BURST: go to IDLE and set rr_ptr = owner + 1 (mod NUM_REQ).
  - On no transfer: bubble_cnt increments. When bubble_cnt reaches IDLE_TIMEOUT: go to IDLE, set rr_ptr = owner + 1 (mod NUM_REQ), and clear bubble_cnt.
  - The IDLE_TIMEOUT release takes effect on the clock edge; no beat is accepted in that cycle.
- Forced release at MAX_BURST does not require last. The requester continues its stream in a later grant.
- After a burst ends, re-arbitration happens in the IDLE cycle that follows. A requester asserting valid continuously therefore sees ready again within NUM_REQ grants (no starvation).
- Back-to-back single-beat grants: one transfer per cycle in IDLE, with the pointer rotating each cycle.
- grant_id holds its value through IDLE until the next grant.

Decomposition:
- Package dual_edge_ff_pkg holds:
  - state_t enum {IDLE, BURST}
  - EDGE_POS = 2'b01, EDGE_NEG = 2'b10, EDGE_BOTH = 2'b11, EDGE_NONE = 2'b00
  - function clog2_min1
- Sub-module rr_pick: combinational round-robin priority picker. Inputs: req vector and rr_ptr. Outputs: one-hot grant, index, any.
- The top level contains the state machine, counters and output register.

Test Plan:
- Reset: assert rst mid-stream -> same cycle, ff_pos_en, ff_neg_en, ff_data_in = 0 and req_ready = 0; after release, rr_ptr = 0, so req0 wins first.
- Single beat: req1 valid, data 0xA5, mask 0xFF, edge 01, last 1 -> next cycle ff_data_in = 0xA5, ff_pos_en = 0xFF, ff_neg_en = 0x00; rr_ptr = 2.
- Fairness: all 4 requesters hold valid with last = 1 every beat -> grants 0,1,2,3,0 on consecutive cycles.
- MAX_BURST: req2 sends 6 beats with last = 0, others idle, MAX_BURST = 4 -> 4 beats accepted, one IDLE cycle, then req2 is regranted for the remaining 2 beats.
- Bubble timeout: req0 starts a burst then drops valid for 8 cycles while req3 is valid -> after 8 bubbles, release; req3 is granted in the next IDLE cycle; enables stay 0 during the bubbles.
- Edge codes: beats with edge 10, mask 0x0F and edge 11, mask 0xF0 -> ff_neg_en = 0x0F, then ff_pos_en = ff_neg_en = 0xF0; edge 00 -> no enables, beat_cnt increments.
